// File: rtl/niosii_oci_dct_pkg.sv
// Shared widths, state encoding and slot-placement helper for the OCI DCT trace packer.
package niosii_oci_dct_pkg;

  localparam int SYM_W = 2;
  localparam int SLOTS = 15;
  localparam int BUF_W = SYM_W * SLOTS;
  localparam int CNT_W = 4;

  typedef logic [BUF_W-1:0] dct_buf_t;
  typedef logic [CNT_W-1:0] dct_cnt_t;
  typedef logic [SYM_W-1:0] dct_sym_t;

  localparam dct_cnt_t FULL_CNT = dct_cnt_t'(SLOTS);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ENDING = 2'd1,
    ENDED  = 2'd2
  } dct_state_e;

  // Writes sym into the given slot; slots at or beyond SLOTS leave the buffer untouched.
  function automatic dct_buf_t place_sym(input dct_buf_t buf_in, input dct_cnt_t slot,
                                         input dct_sym_t sym);
    dct_buf_t v;
    v = buf_in;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot == dct_cnt_t'(i)) v[i*SYM_W +: SYM_W] = sym;
    end
    return v;
  endfunction

endpackage

// File: rtl/niosii_oci_dct_out_reg.sv
// Output holding register: loads a closed buffer, holds it until the consumer takes it.
module niosii_oci_dct_out_reg
  import niosii_oci_dct_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_load,
  input  dct_buf_t i_buf,
  input  dct_cnt_t i_cnt,
  input  logic     i_ready,
  output dct_buf_t o_buf,
  output dct_cnt_t o_cnt,
  output logic     o_valid,
  output logic     o_free
);

  dct_buf_t r_buf;
  dct_cnt_t r_cnt;
  logic     r_valid;

  // A load in the same cycle as a handshake replaces the departing buffer back-to-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_buf;
      r_cnt   <= i_cnt;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_buf   = r_buf;
  assign o_cnt   = r_cnt;
  assign o_valid = r_valid;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/niosii_soc_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace symbols LSB-first into 15-slot buffers and hands them to the DCT consumer.
module niosii_soc_nios2_qsys_0_oci_dct_packer
  import niosii_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic             sym_ready,
  input  logic             flush,
  input  logic             stop_req,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             dct_valid,
  input  logic             dct_ready,
  output logic             test_ending,
  output logic             test_has_ended
);

  dct_state_e r_state;
  logic       r_live;
  logic       r_test_ending;
  logic       r_test_has_ended;
  dct_buf_t   r_asm_buf;
  dct_cnt_t   r_asm_cnt;
  logic       r_closed;

  logic       w_acc;
  logic       w_xfer;
  logic       w_out_free;
  logic       w_close_req;
  dct_buf_t   w_buf_base;
  dct_cnt_t   w_cnt_base;
  dct_buf_t   w_buf_nxt;
  dct_cnt_t   w_cnt_nxt;
  logic       w_closed_nxt;

  niosii_oci_dct_out_reg u_out_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_xfer),
    .i_buf   (r_asm_buf),
    .i_cnt   (r_asm_cnt),
    .i_ready (dct_ready),
    .o_buf   (dct_buffer),
    .o_cnt   (dct_count),
    .o_valid (dct_valid),
    .o_free  (w_out_free)
  );

  // r_live keeps sym_ready low while reset is held and through the release edge.
  assign sym_ready = r_live && (r_state == RUN) && !(r_closed && dct_valid);
  assign w_acc     = sym_valid && sym_ready;
  assign w_xfer    = r_closed && w_out_free;

  // A transfer empties the assembly register first, so a same-cycle symbol lands in slot 0.
  always_comb begin
    w_buf_base  = w_xfer ? '0 : r_asm_buf;
    w_cnt_base  = w_xfer ? '0 : r_asm_cnt;
    w_buf_nxt   = w_buf_base;
    w_cnt_nxt   = w_cnt_base;
    if (w_acc) begin
      w_buf_nxt = place_sym(w_buf_base, w_cnt_base, sym_data);
      w_cnt_nxt = w_cnt_base + dct_cnt_t'(1);
    end
    w_close_req  = flush || (stop_req && (r_state == RUN));
    w_closed_nxt = (r_closed && !w_xfer)
                 || (w_cnt_nxt == FULL_CNT)
                 || (w_close_req && (w_cnt_nxt != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_asm_buf <= '0;
      r_asm_cnt <= '0;
      r_closed  <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_asm_buf <= w_buf_nxt;
      r_asm_cnt <= w_cnt_nxt;
      r_closed  <= w_closed_nxt;
      r_live    <= 1'b1;
    end
  end

  // End-of-trace sequencing; ENDED is left only through reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= RUN;
      r_test_ending    <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (stop_req) begin
            r_state       <= ENDING;
            r_test_ending <= 1'b1;
          end
        end
        ENDING: begin
          if ((r_asm_cnt == '0) && !dct_valid) begin
            r_state          <= ENDED;
            r_test_has_ended <= 1'b1;
          end
        end
        ENDED: begin
          r_state <= ENDED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign test_ending    = r_test_ending;
  assign test_has_ended = r_test_has_ended;

endmodule
